pinwheel_regs_multi: RTL

- Parametrised successor to the two-read/one-write register file macro.
- Generalises word width, depth and read-port count, and adds per-byte write masking, per-port read enables and a hardwired zero register per hart bank.
- Adds a self-clearing sweep after reset, so block RAM contents are defined without an external init pass.
- Sits between decode (read addresses) and writeback (write port) in the multi-hart pipeline.

---
 rtl/pinwheel_regs_multi.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pinwheel_regs_multi.sv
// Multi-port, byte-maskable register file with per-hart zero registers.
// After reset it sweeps every entry to zero before accepting accesses.
module pinwheel_regs_multi #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 256,
    parameter int RPORTS    = 2,
    parameter int HART_REGS = 32,
    parameter int ZERO_REG  = 1,
    localparam int AW       = $clog2(DEPTH),
    localparam int NB       = WIDTH / 8
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    output logic                     ready_o,
    input  logic [RPORTS*AW-1:0]     raddr_i,
    input  logic [RPORTS-1:0]        rden_i,
    output logic [RPORTS*WIDTH-1:0]  rdata_o,
    input  logic [AW-1:0]            waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [NB-1:0]            wmask_i,
    input  logic                     wren_i
);

    // state   | meaning
    // S_CLEAR | zeroing mem[cnt_q], accesses ignored, rdata held at 0
    // S_READY | reads and writes honoured
    typedef enum logic {S_CLEAR, S_READY} state_t;

    localparam logic [AW-1:0] HMASK    = AW'(HART_REGS - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [RPORTS*WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0]    rd_val [RPORTS];

    logic                clr_active;
    logic                wr_eff;
    logic                mem_we;
    logic [AW-1:0]       mem_wa;
    logic [WIDTH-1:0]    mem_wd;
    logic [NB-1:0]       mem_be;

    function automatic logic hart_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && ((a & HMASK) == '0);
    endfunction

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter stops on the last index, so it can never start a second sweep.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_CLEAR) begin
            if (cnt_q == LAST_IDX) begin
                state_d = S_READY;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        clr_active = (state_q == S_CLEAR);
        ready_o    = (state_q == S_READY);
    end

    assign wr_eff = ready_o && !reset_i && wren_i && (|wmask_i) && !hart_zero(waddr_i);

    always_comb begin
        mem_we = 1'b0;
        mem_wa = waddr_i;
        mem_wd = wdata_i;
        mem_be = wmask_i;
        if (!reset_i && clr_active) begin
            mem_we = 1'b1;
            mem_wa = cnt_q;
            mem_wd = '0;
            mem_be = '1;
        end else if (wr_eff) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_wa][8*b +: 8] <= mem_wd[8*b +: 8];
                end
            end
        end
    end

    // Same-cycle write data is forwarded byte by byte into matching reads.
    always_comb begin
        for (int p = 0; p < RPORTS; p++) begin
            rd_val[p] = mem_q[raddr_i[p*AW +: AW]];
            if (wr_eff && (waddr_i == raddr_i[p*AW +: AW])) begin
                for (int b = 0; b < NB; b++) begin
                    if (wmask_i[b]) begin
                        rd_val[p][8*b +: 8] = wdata_i[8*b +: 8];
                    end
                end
            end
            if (hart_zero(raddr_i[p*AW +: AW])) begin
                rd_val[p] = '0;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rdata_q <= '0;
        end else if (ready_o) begin
            for (int p = 0; p < RPORTS; p++) begin
                if (rden_i[p]) begin
                    rdata_q[p*WIDTH +: WIDTH] <= rd_val[p];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule
